// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: walks an LDM/STM register list, one dcache uop per cycle, with optional base writeback.
module ldm_stm_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_increment,
  input  logic        req_before,
  input  logic        req_writeback,
  input  logic [3:0]  req_base_reg,
  input  logic [31:0] req_base,
  input  logic [15:0] req_reglist,
  output logic [3:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_data_in,
  output logic [4:0]  dc_uop,
  input  logic [31:0] dc_data_out,
  output logic        busy,
  output logic        done
);
  localparam logic [4:0] STR_UOP = 5'b01001;
  localparam logic [4:0] LDR_UOP = 5'b01010;
  localparam logic [4:0] NOP_UOP = 5'b00000;
  typedef enum logic [2:0] {IDLE, XFER, DRAIN, WB, DONE} state_t;
  state_t state, state_nx;
  logic load, wb_en, pend_valid, xfer, in_wb;
  logic [3:0] base_reg, pend_reg, r;
  logic [4:0] n;
  logic [15:0] pending, remain;
  logic [31:0] final_base, cur_addr, span, start;
  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, req_reglist[i]};
    span = {25'b0, n, 2'b00};
    start = req_increment ? (req_before ? req_base + 32'd4 : req_base)
                          : (req_before ? req_base - span : req_base - span + 32'd4);
    r = '0;
    for (int i = 15; i >= 0; i--) if (pending[i]) r = 4'(i);
    remain = pending & ~(16'b1 << r);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid ? (req_reglist == '0 ? DONE : XFER) : IDLE;
      XFER:    state_nx = remain != '0 ? XFER : load ? DRAIN : wb_en ? WB : DONE;
      DRAIN:   state_nx = wb_en ? WB : DONE;
      WB:      state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end
  // Load data returns the cycle after issue, so writes trail issues by one cycle.
  always_comb begin
    xfer       = state == XFER;
    in_wb      = state == WB;
    req_ready  = state == IDLE;
    busy       = state != IDLE;
    done       = state == DONE;
    dc_uop     = xfer ? (load ? LDR_UOP : STR_UOP) : NOP_UOP;
    dc_addr    = xfer ? cur_addr : '0;
    rf_raddr   = xfer && !load ? r : '0;
    dc_data_in = xfer && !load ? rf_rdata : '0;
    rf_we      = pend_valid | in_wb;
    rf_waddr   = pend_valid ? pend_reg : in_wb ? base_reg : '0;
    rf_wdata   = pend_valid ? dc_data_out : in_wb ? final_base : '0;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      load       <= 1'b0;
      wb_en      <= 1'b0;
      base_reg   <= '0;
      final_base <= '0;
      cur_addr   <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
      pend_reg   <= '0;
    end else begin
      state      <= state_nx;
      pend_valid <= xfer && load;
      pend_reg   <= r;
      if (req_ready && req_valid) begin
        load       <= req_load;
        wb_en      <= req_writeback & ~(req_load & req_reglist[req_base_reg]);
        base_reg   <= req_base_reg;
        final_base <= req_increment ? req_base + span : req_base - span;
        cur_addr   <= start;
        pending    <= req_reglist;
      end else if (xfer) begin
        pending  <= remain;
        cur_addr <= cur_addr + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed and random LDM/STM requests checked cycle by cycle against a transfer-list model.
module tb_ldm_stm_sequencer;
  localparam logic [4:0] STR = 5'b01001;
  localparam logic [4:0] LDR = 5'b01010;
  localparam logic [4:0] NOP = 5'b00000;
  logic clock = 0, reset_n = 0, req_valid = 0, req_load = 0, req_increment = 0, req_before = 0, req_writeback = 0;
  logic [3:0] req_base_reg = 0;
  logic [31:0] req_base = 0;
  logic [15:0] req_reglist = 0;
  logic req_ready, rf_we, busy, done;
  logic [3:0] rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata, dc_addr, dc_data_in, dc_data_out;
  logic [4:0] dc_uop;
  logic [31:0] rf [16];
  logic [31:0] rf_seed [16];
  logic seed_go = 0;
  logic [31:0] mem [logic [31:0]];
  int checks = 0, failures = 0;

  ldm_stm_sequencer dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_increment(req_increment), .req_before(req_before),
    .req_writeback(req_writeback), .req_base_reg(req_base_reg), .req_base(req_base),
    .req_reglist(req_reglist), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dc_addr(dc_addr), .dc_data_in(dc_data_in),
    .dc_uop(dc_uop), .dc_data_out(dc_data_out), .busy(busy), .done(done));

  always #5 clock = ~clock;
  assign rf_rdata = rf[rf_raddr];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  always @(posedge clock) begin
    if (seed_go) for (int i = 0; i < 16; i++) rf[i] <= rf_seed[i];
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    if (dc_uop == STR) mem[dc_addr] = dc_data_in;
    dc_data_out <= (dc_uop == LDR) ? mrd(dc_addr) : 32'hDEADBEEF;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, " req_ready"}, 32'(req_ready), 1);
    chk({p, " busy"}, 32'(busy), 0);
    chk({p, " done"}, 32'(done), 0);
    chk({p, " rf_we"}, 32'(rf_we), 0);
    chk({p, " rf_waddr"}, 32'(rf_waddr), 0);
    chk({p, " rf_wdata"}, rf_wdata, 0);
    chk({p, " dc_uop"}, 32'(dc_uop), 32'(NOP));
    chk({p, " dc_addr"}, dc_addr, 0);
    chk({p, " dc_data_in"}, dc_data_in, 0);
  endtask

  task automatic apply_seed();
    @(negedge clock);
    seed_go = 1;
    @(negedge clock);
    seed_go = 0;
  endtask

  task automatic send(input logic ld, inc, bef, wb, input logic [3:0] br, input logic [31:0] base, input logic [15:0] list);
    @(negedge clock);
    chk("accept ready", 32'(req_ready), 1);
    req_valid = 1; req_load = ld; req_increment = inc; req_before = bef; req_writeback = wb;
    req_base_reg = br; req_base = base; req_reglist = list;
    @(posedge clock);
    #1 req_valid = 0;
  endtask

  task automatic run_op(input logic ld, inc, bef, wb, input logic [3:0] br, input logic [31:0] base,
                        input logic [15:0] list, input bit poke);
    int n, total;
    logic [3:0] regs[$];
    logic [31:0] snap [16];
    logic [31:0] ldv [16];
    logic [31:0] exp_rf [16];
    logic [31:0] start, fin, e_addr, e_din, e_wd;
    logic [4:0] e_uop;
    logic [3:0] e_wa;
    logic e_we;
    bit wbe;
    n = $countones(list);
    for (int i = 0; i < 16; i++) if (list[i]) regs.push_back(4'(i));
    start = inc ? (bef ? base + 32'd4 : base) : (bef ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4);
    fin = inc ? base + 32'(4 * n) : base - 32'(4 * n);
    snap = rf;
    for (int k = 0; k < 16; k++) ldv[k] = mrd(start + 32'(4 * k));
    wbe = wb && n != 0 && !(ld && list[br]);
    total = (n == 0) ? 1 : n + int'(ld) + int'(wbe) + 1;
    send(ld, inc, bef, wb, br, base, list);
    for (int c = 1; c <= total; c++) begin
      @(negedge clock);
      if (poke && c == 2) begin
        chk("busy ready", 32'(req_ready), 0);
        req_valid = 1; req_load = ~ld; req_reglist = 16'hFFFF; req_base = 32'h12345678;
      end
      if (c == 3) req_valid = 0;
      e_uop = c <= n ? (ld ? LDR : STR) : NOP;
      e_addr = c <= n ? start + 32'(4 * (c - 1)) : 0;
      e_din = (!ld && c <= n) ? snap[regs[c - 1]] : 0;
      e_we = 0; e_wa = 0; e_wd = 0;
      if (ld && c >= 2 && c <= n + 1) begin
        e_we = 1; e_wa = regs[c - 2]; e_wd = ldv[c - 2];
      end else if (wbe && c == total - 1) begin
        e_we = 1; e_wa = br; e_wd = fin;
      end
      chk($sformatf("c%0d dc_uop", c), 32'(dc_uop), 32'(e_uop));
      chk($sformatf("c%0d dc_addr", c), dc_addr, e_addr);
      chk($sformatf("c%0d dc_data_in", c), dc_data_in, e_din);
      chk($sformatf("c%0d rf_we", c), 32'(rf_we), 32'(e_we));
      chk($sformatf("c%0d rf_waddr", c), 32'(rf_waddr), 32'(e_wa));
      chk($sformatf("c%0d rf_wdata", c), rf_wdata, e_wd);
      chk($sformatf("c%0d busy", c), 32'(busy), 1);
      chk($sformatf("c%0d done", c), 32'(done), 32'(c == total));
    end
    @(negedge clock);
    req_valid = 0;
    chk("after done", 32'(done), 0);
    chk("after ready", 32'(req_ready), 1);
    chk("after uop", 32'(dc_uop), 32'(NOP));
    exp_rf = snap;
    if (ld) for (int k = 0; k < n; k++) exp_rf[regs[k]] = ldv[k];
    if (wbe) exp_rf[br] = fin;
    for (int i = 0; i < 16; i++) chk($sformatf("rf[%0d]", i), rf[i], exp_rf[i]);
    if (!ld) for (int k = 0; k < n; k++) chk($sformatf("mem st%0d", k), mrd(start + 32'(4 * k)), snap[regs[k]]);
  endtask

  initial begin
    logic [15:0] lst;
    logic [3:0] br;
    #3 check_reset("reset");
    for (int i = 0; i < 16; i++) rf_seed[i] = $urandom;
    @(negedge clock);
    reset_n = 1;
    apply_seed();
    rf_seed[1] = 32'h11111111; rf_seed[2] = 32'h22222222; rf_seed[5] = 32'h55555555; rf_seed[13] = 32'h100;
    apply_seed();
    run_op(0, 1, 0, 1, 4'd13, 32'h100, 16'h0026, 0);
    chk("stmia r13", rf[13], 32'h10C);
    chk("stmia mem108", mrd(32'h108), 32'h55555555);
    run_op(1, 0, 1, 0, 4'd9, 32'h200, 16'h8001, 0);
    chk("ldmdb r0", rf[0], mrd(32'h1F8));
    chk("ldmdb r15", rf[15], mrd(32'h1FC));
    run_op(1, 1, 0, 1, 4'd3, 32'h400, 16'h0018, 0);
    chk("ldmia r3 loaded", rf[3], mrd(32'h400));
    run_op(0, 1, 0, 1, 4'd5, 32'h500, 16'h0000, 0);
    run_op(1, 0, 0, 1, 4'd7, 32'h600, 16'h0000, 0);
    run_op(0, 1, 1, 1, 4'd6, 32'hFFFFFFF8, 16'h0003, 0);
    chk("wrap r6", rf[6], 32'h0);
    chk("wrap mem0", mrd(32'h0), rf[1]);
    run_op(0, 0, 1, 1, 4'd4, 32'h800, 16'h0014, 0);
    send(1, 1, 0, 1, 4'd2, 32'h300, 16'h00F0);
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 0;
    #1 check_reset("abort");
    @(negedge clock);
    reset_n = 1;
    run_op(0, 1, 0, 1, 4'd13, 32'h900, 16'h0F0F, 0);
    run_op(0, 0, 0, 1, 4'd0, 32'hA00, 16'h7FFE, 1);
    run_op(1, 1, 1, 1, 4'd14, 32'hB00, 16'h00FF, 1);
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 16; i++) rf_seed[i] = $urandom;
      apply_seed();
      lst = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'($urandom);
      br = 4'($urandom_range(0, 15));
      run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), br, $urandom & 32'hFFFFFFFC, lst,
             1'($urandom_range(0, 3) == 0));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
